// File: rtl/rv32_pkg.sv
// Shared RV32 constants for the fetch path.
//   NOP_INSTR        : canonical NOP (addi x0, x0, 0) shown on an empty decode slot
//   RS1_LSB/RS2_LSB  : bit positions of the rs1/rs2 register fields
//   REG_W            : register index width
//   DEFAULT_RESET_PC : first fetch address after reset unless overridden
package rv32_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int          RS1_LSB          = 15;
  localparam int          RS2_LSB          = 20;
  localparam int          REG_W            = 5;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifetch_queue_if.sv
// Bus bundle between the instruction bus, the fetch queue and the decode stage.
//   iaddr/idata/iready_n : instruction bus (iready_n low = idata valid for iaddr)
//   redir_*              : ID-stage (early) and MEM-stage (late) redirects
//   out_*                : head entry presented to decode, plus pre-decoded rs1/rs2
//   fetch_busy           : queue has room, so a fetch is outstanding on the bus
//
// Handshakes: a fetch completes at a clock edge where fetch_busy=1 and
// iready_n=0; the head entry is consumed at a clock edge where out_valid=1
// and out_stall=0. Neither side may make its valid depend combinationally on
// the other side's ready (fetch_busy never depends on out_stall).
interface ifetch_queue_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] iaddr;
  logic [31:0]     idata;
  logic            iready_n;
  logic            redir_early;
  logic [XLEN-1:0] redir_early_pc;
  logic            redir_late;
  logic [XLEN-1:0] redir_late_pc;
  logic            out_stall;
  logic            out_valid;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pcp4;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic            fetch_busy;

  // master: the fetch queue itself
  modport master (
    output iaddr, out_valid, out_instr, out_pc, out_pcp4, out_rs1, out_rs2, fetch_busy,
    input  idata, iready_n, redir_early, redir_early_pc, redir_late, redir_late_pc, out_stall
  );

  // slave: the surrounding core / bus / decode side
  modport slave (
    input  iaddr, out_valid, out_instr, out_pc, out_pcp4, out_rs1, out_rs2, fetch_busy,
    output idata, iready_n, redir_early, redir_early_pc, redir_late, redir_late_pc, out_stall
  );
endinterface

// File: rtl/ifq_fifo.sv
// DEPTH x W storage FIFO for the fetch queue.
//   clk, rst : clock and synchronous active-high reset
//   flush    : empties the FIFO at the next edge (redirect); wins over wr/rd
//   wr_en    : write wr_data at the tail (ignored when full)
//   rd_en    : drop the head entry (ignored when empty)
//   rd_data  : head entry, combinational from storage
//   count    : occupancy, 0..DEPTH
module ifq_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          wr_ok;
  logic          rd_ok;

  // Full blocks a write even if a read happens in the same cycle.
  assign wr_ok   = wr_en && (count != CW'(DEPTH));
  assign rd_ok   = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; empty entries are masked by the consumer.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: prefetches {PC, instruction} pairs from the
// instruction bus into a DEPTH-entry FIFO and presents the head to decode.
//   clk, rst : clock and synchronous active-high reset
//   bus      : ifetch_queue_if.master (instruction bus, redirects, decode side)
// Redirect priority: rst > redir_late > redir_early > push/pop. A redirect
// empties the queue and cancels any push/pop of that cycle.
module ifetch_queue
  import rv32_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input logic            clk,
  input logic            rst,
  ifetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = XLEN + 32;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   count;
  logic [EW-1:0]   head;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_instr;
  logic            redirect;
  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] redir_pc;
  logic            fetch_busy;
  logic            valid;
  logic            push;
  logic            pop;

  always_comb begin
    redirect  = bus.redir_late || bus.redir_early;
    redir_tgt = bus.redir_late ? bus.redir_late_pc : bus.redir_early_pc;
    // Targets are word aligned: low two bits are dropped.
    redir_pc  = redir_tgt & ~XLEN'(3);
  end

  // fetch_busy comes only from the registered count, never from out_stall,
  // so a full queue will not accept data even while it is being drained.
  assign fetch_busy = (count < CW'(DEPTH));
  assign valid      = (count != '0);
  assign push       = fetch_busy && !bus.iready_n && !redirect;
  assign pop        = valid && !bus.out_stall && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redir_pc;
    end else if (push) begin
      fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  ifq_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect),
    .wr_en   (push),
    .wr_data ({fetch_pc, bus.idata}),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count)
  );

  assign head_pc    = head[EW-1:32];
  assign head_instr = head[31:0];

  // Empty queue shows a NOP at PC 0 so decode never sees stale storage.
  always_comb begin
    bus.iaddr      = fetch_pc;
    bus.fetch_busy = fetch_busy;
    bus.out_valid  = valid;
    bus.out_instr  = valid ? head_instr : NOP_INSTR;
    bus.out_pc     = valid ? head_pc : '0;
    bus.out_pcp4   = valid ? head_pc + XLEN'(4) : '0;
    bus.out_rs1    = bus.out_instr[RS1_LSB +: REG_W];
    bus.out_rs2    = bus.out_instr[RS2_LSB +: REG_W];
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue: a hand-computed vector table, directed corner
// sequences, and a long randomized run against a queue-based reference model.
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_queue_if #(.XLEN(32)) bus ();

  ifetch_queue #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard / model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      m_q[$];
  logic [31:0] m_pc;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Instruction memory contents seen on the bus (fixed pattern, one known word).
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h00A2_8293;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pcp4;
    e_instr = (m_q.size() != 0) ? m_q[0].instr : NOP;
    e_pc    = (m_q.size() != 0) ? m_q[0].pc : 32'h0;
    e_pcp4  = (m_q.size() != 0) ? m_q[0].pc + 32'd4 : 32'h0;
    chk("m_valid", {31'b0, bus.out_valid}, {31'b0, m_q.size() != 0});
    chk("m_busy",  {31'b0, bus.fetch_busy}, {31'b0, m_q.size() < DEPTH});
    chk("m_iaddr", bus.iaddr, m_pc);
    chk("m_instr", bus.out_instr, e_instr);
    chk("m_pc",    bus.out_pc, e_pc);
    chk("m_pcp4",  bus.out_pcp4, e_pcp4);
    chk("m_rs1",   {27'b0, bus.out_rs1}, {27'b0, e_instr[19:15]});
    chk("m_rs2",   {27'b0, bus.out_rs2}, {27'b0, e_instr[24:20]});
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs, advances model and DUT by one edge, compares.
  task automatic step(input logic r, input logic rn, input logic st,
                      input logic le, input logic [31:0] lpc,
                      input logic ee, input logic [31:0] epc);
    logic do_pop;
    logic do_push;
    rst                = r;
    bus.iready_n       = rn;
    bus.out_stall      = st;
    bus.redir_late     = le;
    bus.redir_late_pc  = lpc;
    bus.redir_early    = ee;
    bus.redir_early_pc = epc;
    bus.idata          = rn ? 32'hDEAD_BEEF : mem_f(bus.iaddr);
    @(posedge clk);
    if (r) begin
      m_pc = RESET_PC;
      m_q.delete();
    end else if (le) begin
      m_pc = lpc & ~32'd3;
      m_q.delete();
    end else if (ee) begin
      m_pc = epc & ~32'd3;
      m_q.delete();
    end else begin
      do_pop  = (m_q.size() != 0) && !st;
      do_push = (m_q.size() < DEPTH) && !rn;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back('{pc: m_pc, instr: mem_f(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
    model_check();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        r, rn, st, le;
    logic [31:0] lpc;
    logic        ee;
    logic [31:0] epc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_iaddr;
    logic        e_busy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, input logic rn, input logic st,
                              input logic le, input logic [31:0] lpc,
                              input logic ee, input logic [31:0] epc,
                              input logic ev, input logic [31:0] epcv,
                              input logic [31:0] eia, input logic eb);
    vec_t v;
    v.r = r; v.rn = rn; v.st = st; v.le = le; v.lpc = lpc; v.ee = ee; v.epc = epc;
    v.e_valid = ev; v.e_pc = epcv; v.e_iaddr = eia; v.e_busy = eb;
    return v;
  endfunction

  initial begin
    int pops;
    int budget;
    logic [31:0] exp_next;
    logic rn;
    logic st;

    rst = 1'b1;
    bus.iready_n = 1'b1; bus.out_stall = 1'b0; bus.idata = '0;
    bus.redir_late = 1'b0; bus.redir_late_pc = '0;
    bus.redir_early = 1'b0; bus.redir_early_pc = '0;
    m_pc = RESET_PC;
    step(1, 1, 0, 0, 0, 0, 0);

    // Reset state, explicit constants.
    chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_instr", bus.out_instr, NOP);
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_pcp4", bus.out_pcp4, 32'h0);
    chk("rst_iaddr", bus.iaddr, RESET_PC);

    //            r  rn st le lpc          ee epc    | valid pc         iaddr        busy
    vt.push_back(mk(1, 1, 0, 0, 0,           0, 0,      0, 32'h0,   32'h0,   1));
    // streaming with no stall
    vt.push_back(mk(0, 0, 0, 0, 0,           0, 0,      1, 32'h0,   32'h4,   1));
    vt.push_back(mk(0, 0, 0, 0, 0,           0, 0,      1, 32'h4,   32'h8,   1));
    vt.push_back(mk(0, 0, 0, 0, 0,           0, 0,      1, 32'h8,   32'hC,   1));
    // fill to full under stall, then drain
    vt.push_back(mk(1, 1, 0, 0, 0,           0, 0,      0, 32'h0,   32'h0,   1));
    vt.push_back(mk(0, 0, 1, 0, 0,           0, 0,      1, 32'h0,   32'h4,   1));
    vt.push_back(mk(0, 0, 1, 0, 0,           0, 0,      1, 32'h0,   32'h8,   1));
    vt.push_back(mk(0, 0, 1, 0, 0,           0, 0,      1, 32'h0,   32'hC,   1));
    vt.push_back(mk(0, 0, 1, 0, 0,           0, 0,      1, 32'h0,   32'h10,  0));
    vt.push_back(mk(0, 0, 1, 0, 0,           0, 0,      1, 32'h0,   32'h10,  0));
    vt.push_back(mk(0, 0, 0, 0, 0,           0, 0,      1, 32'h4,   32'h10,  1));
    vt.push_back(mk(0, 0, 0, 0, 0,           0, 0,      1, 32'h8,   32'h14,  1));
    vt.push_back(mk(0, 0, 0, 0, 0,           0, 0,      1, 32'hC,   32'h18,  1));
    vt.push_back(mk(0, 0, 0, 0, 0,           0, 0,      1, 32'h10,  32'h1C,  1));
    // late redirect with 3 entries queued and data returning that cycle
    vt.push_back(mk(0, 0, 0, 1, 32'h200,     0, 0,      0, 32'h0,   32'h200, 1));
    vt.push_back(mk(0, 0, 1, 0, 0,           0, 0,      1, 32'h200, 32'h204, 1));
    // simultaneous early and late redirect: late wins
    vt.push_back(mk(0, 0, 0, 1, 32'h300,     1, 32'h80, 0, 32'h0,   32'h300, 1));
    vt.push_back(mk(0, 0, 1, 0, 0,           0, 0,      1, 32'h300, 32'h304, 1));
    // early-only redirect, unaligned target
    vt.push_back(mk(0, 0, 0, 0, 0,           1, 32'h81, 0, 32'h0,   32'h80,  1));
    vt.push_back(mk(0, 0, 1, 0, 0,           0, 0,      1, 32'h80,  32'h84,  1));

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].r, vt[i].rn, vt[i].st, vt[i].le, vt[i].lpc, vt[i].ee, vt[i].epc);
      chk($sformatf("vec%0d_valid", i), {31'b0, bus.out_valid}, {31'b0, vt[i].e_valid});
      chk($sformatf("vec%0d_pc", i), bus.out_pc, vt[i].e_pc);
      chk($sformatf("vec%0d_pcp4", i), bus.out_pcp4,
          vt[i].e_valid ? vt[i].e_pc + 32'd4 : 32'h0);
      chk($sformatf("vec%0d_iaddr", i), bus.iaddr, vt[i].e_iaddr);
      chk($sformatf("vec%0d_busy", i), {31'b0, bus.fetch_busy}, {31'b0, vt[i].e_busy});
    end

    // Unaligned late redirect, then the known instruction's register fields.
    step(0, 1, 0, 1, 32'h103, 0, 0);
    chk("r103_iaddr", bus.iaddr, 32'h100);
    chk("r103_valid", {31'b0, bus.out_valid}, 32'd0);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("r103_instr", bus.out_instr, 32'h00A2_8293);
    chk("r103_rs1", {27'b0, bus.out_rs1}, 32'd5);
    chk("r103_rs2", {27'b0, bus.out_rs2}, 32'd10);
    chk("r103_pc", bus.out_pc, 32'h100);

    // Address wrap at the top of the space.
    step(0, 1, 0, 1, 32'hFFFF_FFFE, 0, 0);
    chk("wrap_iaddr0", bus.iaddr, 32'hFFFF_FFFC);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("wrap_pc", bus.out_pc, 32'hFFFF_FFFC);
    chk("wrap_pcp4", bus.out_pcp4, 32'h0);
    chk("wrap_iaddr1", bus.iaddr, 32'h0);

    // Fill/drain wrap: 11 pops with random stall/ready, PCs strictly +4.
    step(1, 1, 0, 0, 0, 0, 0);
    pops = 0;
    budget = 0;
    exp_next = RESET_PC;
    while (pops < 11 && budget < 600) begin
      rn = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 2) == 0);
      if (bus.out_valid && !st) begin
        chk($sformatf("seq_pc%0d", pops), bus.out_pc, exp_next);
        exp_next = exp_next + 32'd4;
        pops++;
      end
      step(0, rn, st, 0, 0, 0, 0);
      budget++;
    end
    if (pops < 11) chk("seq_timeout", pops, 11);
    // Reset mid-stream.
    step(1, 0, 0, 0, 0, 0, 0);
    chk("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("midrst_iaddr", bus.iaddr, RESET_PC);

    // Long randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 99) < 2, $urandom,
           $urandom_range(0, 99) < 3, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
